sd_mseq_check: RTL and testbench

//  Multi-channel srdy/drdy traffic checker for bench environments. Sinks one

---
 rtl/sd_mseq_check.sv | 137 +++++++++++++
 tb/tb_sd_mseq_check.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_mseq_check.sv
// sd_mseq_check: sinks one srdy/drdy stream, checks per-channel stepped sequences,
// drives pattern-based drdy backpressure. Define SDLIB_SEQ_TIMEOUT_EN for the idle watchdog.
module sd_mseq_check #(
   parameter int width    = 8,
   parameter int channels = 4,
   parameter int chan_w   = 2,
   parameter int pat_dep  = 8,
   parameter int cnt_w    = 16,
   parameter int timeout  = 256
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               c_srdy,
   output logic               c_drdy,
   input  logic [width-1:0]   c_data,
   input  logic [chan_w-1:0]  c_chan,
   input  logic [width-1:0]   cfg_step,
   input  logic [pat_dep-1:0] cfg_drdy_pat,
   input  logic               clr,
   output logic [cnt_w-1:0]   ok_cnt,
   output logic [cnt_w-1:0]   err_cnt,
   output logic               err_flag,
   output logic [chan_w-1:0]  err_chan,
   output logic [width-1:0]   err_rcv,
   output logic [width-1:0]   err_exp,
   output logic               timeout_err
);

   localparam int CH_N  = 1 << chan_w;
   localparam int PTR_W = (pat_dep > 1) ? $clog2(pat_dep) : 1;
   localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(pat_dep - 1);

   if (timeout < 1 || channels < 1 || channels > CH_N) begin : g_param_err
      $error("sd_mseq_check: illegal timeout/channels parameter");
   end

   function automatic logic [cnt_w-1:0] sat_inc(input logic [cnt_w-1:0] v);
      return (&v) ? v : v + {{(cnt_w-1){1'b0}}, 1'b1};
   endfunction

   logic [PTR_W-1:0] ptr;
   logic [CH_N-1:0]  first;
   logic [width-1:0] last_seq [CH_N];
   logic             xfer;
   logic             chan_ok;
   logic             beat_err;
   logic [width-1:0] exp_data;
   logic [width-1:0] cap_exp;

   assign xfer = c_srdy & c_drdy;

   // Beat check against the channel's last accepted value
   always_comb begin
      chan_ok  = (int'(c_chan) < channels);
      exp_data = last_seq[c_chan] + cfg_step;
      beat_err = !chan_ok || (!first[c_chan] && (c_data != exp_data));
      // An out-of-range channel has no sequence, so its captured expectation is 0.
      cap_exp  = chan_ok ? exp_data : '0;
   end

   // Backpressure: a slot is consumed whenever the current drdy was used or was low
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         c_drdy <= 1'b0;
         ptr    <= '0;
      end else if (xfer || !c_drdy) begin
         c_drdy <= cfg_drdy_pat[ptr];
         ptr    <= (ptr == PTR_MAX) ? '0 : ptr + PTR_W'(1);
      end
   end

   // Check state and counters; clr overrides any beat in the same cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         first    <= '1;
         for (int i = 0; i < CH_N; i++) last_seq[i] <= '0;
         ok_cnt   <= '0;
         err_cnt  <= '0;
         err_flag <= 1'b0;
         err_chan <= '0;
         err_rcv  <= '0;
         err_exp  <= '0;
      end else if (clr) begin
         first    <= '1;
         for (int i = 0; i < CH_N; i++) last_seq[i] <= '0;
         ok_cnt   <= '0;
         err_cnt  <= '0;
         err_flag <= 1'b0;
         err_chan <= '0;
         err_rcv  <= '0;
         err_exp  <= '0;
      end else if (xfer) begin
         if (beat_err) begin
            err_cnt  <= sat_inc(err_cnt);
            err_flag <= 1'b1;
            if (!err_flag) begin
               err_chan <= c_chan;
               err_rcv  <= c_data;
               err_exp  <= cap_exp;
            end
         end else begin
            ok_cnt <= sat_inc(ok_cnt);
         end
         // Resync on mismatch so a single bad beat costs exactly one error.
         if (chan_ok) begin
            last_seq[c_chan] <= c_data;
            first[c_chan]    <= 1'b0;
         end
      end
   end

`ifdef SDLIB_SEQ_TIMEOUT_EN
   localparam int IDLE_W = $clog2(timeout + 1);
   localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(timeout);

   logic [IDLE_W-1:0] idle_cnt;

   // Watchdog arms only once some channel has delivered its first beat
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idle_cnt    <= '0;
         timeout_err <= 1'b0;
      end else if (clr) begin
         idle_cnt    <= '0;
         timeout_err <= 1'b0;
      end else if (xfer) begin
         idle_cnt <= '0;
      end else if (!(&first)) begin
         if (idle_cnt != IDLE_LIM) idle_cnt <= idle_cnt + IDLE_W'(1);
         if (idle_cnt >= IDLE_LIM - IDLE_W'(1)) timeout_err <= 1'b1;
      end
   end
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_sd_mseq_check.sv
// Randomized and directed bench for sd_mseq_check against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_sd_mseq_check;

   localparam int W = 8, CH = 3, CW = 2, PD = 8, CNTW = 6, TO = 16;
   localparam int CNT_MAX = (1 << CNTW) - 1;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          c_srdy;
   logic          c_drdy;
   logic [W-1:0]  c_data;
   logic [CW-1:0] c_chan;
   logic [W-1:0]  cfg_step;
   logic [PD-1:0] cfg_drdy_pat;
   logic          clr;
   logic [CNTW-1:0] ok_cnt, err_cnt;
   logic          err_flag;
   logic [CW-1:0] err_chan;
   logic [W-1:0]  err_rcv, err_exp;
   logic          timeout_err;

   int n_chk = 0, n_pass = 0;
   bit mon_en = 0;

   sd_mseq_check #(.width(W), .channels(CH), .chan_w(CW), .pat_dep(PD),
                   .cnt_w(CNTW), .timeout(TO)) dut (
      .clk(clk), .reset_n(reset_n), .c_srdy(c_srdy), .c_drdy(c_drdy),
      .c_data(c_data), .c_chan(c_chan), .cfg_step(cfg_step),
      .cfg_drdy_pat(cfg_drdy_pat), .clr(clr), .ok_cnt(ok_cnt), .err_cnt(err_cnt),
      .err_flag(err_flag), .err_chan(err_chan), .err_rcv(err_rcv),
      .err_exp(err_exp), .timeout_err(timeout_err));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
   endtask

   // Behavioural model: per-channel sequence memory, integer counters with clamping
   bit m_drdy;
   int m_ptr;
   bit m_first [4];
   int m_last [4];
   int m_ok, m_err, m_echan, m_ercv, m_eexp, m_idle;
   bit m_eflag, m_to;

   always @(posedge clk or negedge reset_n) begin
      int ch, e;
      bit x, bad, started;
      if (!reset_n) begin
         m_drdy = 0; m_ptr = 0; m_ok = 0; m_err = 0; m_eflag = 0;
         m_echan = 0; m_ercv = 0; m_eexp = 0; m_idle = 0; m_to = 0;
         for (int i = 0; i < 4; i++) begin m_first[i] = 1; m_last[i] = 0; end
      end else begin
         x = c_srdy && m_drdy;
         started = 0;
         for (int i = 0; i < CH; i++) if (!m_first[i]) started = 1;
         if (x || !m_drdy) begin
            m_drdy = cfg_drdy_pat[m_ptr];
            m_ptr = (m_ptr + 1) % PD;
         end
         if (clr) begin
            m_ok = 0; m_err = 0; m_eflag = 0; m_echan = 0; m_ercv = 0; m_eexp = 0;
            m_idle = 0; m_to = 0;
            for (int i = 0; i < 4; i++) begin m_first[i] = 1; m_last[i] = 0; end
         end else begin
            if (x) begin
               ch = int'(c_chan);
               e = 0;
               if (ch >= CH) bad = 1;
               else if (m_first[ch]) bad = 0;
               else begin
                  e = (m_last[ch] + int'(cfg_step)) % 256;
                  bad = (int'(c_data) != e);
               end
               if (bad) begin
                  m_err = (m_err < CNT_MAX) ? m_err + 1 : CNT_MAX;
                  if (!m_eflag) begin m_echan = ch; m_ercv = int'(c_data); m_eexp = e; end
                  m_eflag = 1;
               end else m_ok = (m_ok < CNT_MAX) ? m_ok + 1 : CNT_MAX;
               if (ch < CH) begin m_last[ch] = int'(c_data); m_first[ch] = 0; end
               m_idle = 0;
            end else if (started) begin
               m_idle = (m_idle < TO) ? m_idle + 1 : TO;
               if (m_idle == TO) m_to = 1;
            end
`ifndef SDLIB_SEQ_TIMEOUT_EN
            m_to = 0;
`endif
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         chk("c_drdy", c_drdy, m_drdy);
         chk("ok_cnt", ok_cnt, m_ok);
         chk("err_cnt", err_cnt, m_err);
         chk("err_flag", err_flag, m_eflag);
         chk("err_chan", err_chan, m_echan);
         chk("err_rcv", err_rcv, m_ercv);
         chk("err_exp", err_exp, m_eexp);
         chk("timeout_err", timeout_err, m_to);
      end
   end

   // Called #1 after a rising edge; returns #1 after the edge that accepted the beat.
   task automatic send(input int ch, input int d);
      bit will;
      int n = 0;
      c_srdy = 1; c_chan = CW'(ch); c_data = W'(d);
      do begin
         will = m_drdy;
         @(posedge clk); #1;
         n++;
      end while (!will && n < 64);
      c_srdy = 0;
      chk("beat_accepted", will, 1);
   endtask

   task automatic idle(input int n);
      c_srdy = 0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_clr();
      clr = 1;
      @(posedge clk); #1;
      clr = 0;
   endtask

   initial begin
      int n, guard, r, ch;
      bit will;
      reset_n = 0; c_srdy = 0; c_data = '0; c_chan = '0; clr = 0;
      cfg_step = 8'd1; cfg_drdy_pat = 8'hFF;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_drdy", c_drdy, 0);
      chk("rst_ok", ok_cnt, 0);
      chk("rst_err", err_cnt, 0);
      chk("rst_flag", err_flag, 0);
      reset_n = 1;
      mon_en = 1;

      // All-ones pattern, ch0 counts 0..9
      idle(2);
      chk("drdy_allones", c_drdy, 1);
      for (int i = 0; i < 10; i++) send(0, i);
      chk("t1_ok", ok_cnt, 10);
      chk("t1_err", err_cnt, 0);

      // Interleaved channels, one corrupted beat, then resync
      do_clr();
      send(0, 0); send(0, 1); send(1, 8'h40); send(0, 2); send(1, 8'h41); send(0, 4);
      chk("t2_err", err_cnt, 1);
      chk("t2_chan", err_chan, 0);
      chk("t2_rcv", err_rcv, 4);
      chk("t2_exp", err_exp, 3);
      send(0, 5);
      chk("t2_resync_err", err_cnt, 1);
      chk("t2_resync_ok", ok_cnt, 6);

      // Wrap at step 3, then an out-of-range channel
      do_clr();
      cfg_step = 8'd3;
      send(2, 8'hFD); send(2, 8'h00); send(2, 8'h03);
      chk("t3_wrap_err", err_cnt, 0);
      chk("t3_wrap_ok", ok_cnt, 3);
      send(3, 8'h55);
      chk("t3_badch_err", err_cnt, 1);
      chk("t3_badch_chan", err_chan, 3);

      // Patterned backpressure with an always-valid producer; ok_cnt saturates at 63
      do_clr();
      cfg_drdy_pat = 8'b1010_0110;
      c_srdy = 1; c_chan = 0;
      n = 0; guard = 0;
      while (n < 64 && guard < 400) begin
         c_data = m_first[0] ? 8'h10 : W'(m_last[0] + int'(cfg_step));
         will = m_drdy;
         @(posedge clk); #1;
         guard++;
         if (will) n++;
         if (n == 30) cfg_drdy_pat = 8'b1100_1011;
      end
      c_srdy = 0;
      chk("t4_beats", n, 64);
      chk("t4_ok_sat", ok_cnt, CNT_MAX);
      chk("t4_err", err_cnt, 0);

      // clr coincident with a beat
      cfg_drdy_pat = 8'hFF;
      idle(3);
      send(1, 7);
      c_srdy = 1; c_chan = 1; c_data = 8'd99; clr = 1;
      chk("t5_drdy_pre", c_drdy, 1);
      @(posedge clk); #1;
      clr = 0; c_srdy = 0;
      chk("t5_clr_ok", ok_cnt, 0);
      chk("t5_clr_err", err_cnt, 0);
      send(2, 55); send(1, 200);
      chk("t5_first_ok", ok_cnt, 2);
      chk("t5_first_err", err_cnt, 0);

      // Asynchronous reset in the middle of a stream
      c_srdy = 1; c_chan = 2;
      repeat (4) begin
         c_data = W'(m_last[2] + int'(cfg_step));
         @(posedge clk); #1;
      end
      #2;
      reset_n = 0;
      #1;
      chk("t5_rst_drdy", c_drdy, 0);
      chk("t5_rst_ok", ok_cnt, 0);
      chk("t5_rst_err", err_cnt, 0);
      chk("t5_rst_flag", err_flag, 0);
      chk("t5_rst_rcv", err_rcv, 0);
      chk("t5_rst_to", timeout_err, 0);
      @(posedge clk); #1;
      reset_n = 1; c_srdy = 0;

      // Watchdog: one beat, then idle
      send(0, 1);
      idle(15);
      chk("t6_to_early", timeout_err, 0);
      idle(1);
`ifdef SDLIB_SEQ_TIMEOUT_EN
      chk("t6_to_set", timeout_err, 1);
`else
      chk("t6_to_off", timeout_err, 0);
`endif

      // Random traffic, patterns, steps and clears
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(99) == 0) cfg_drdy_pat = PD'($urandom);
         if ($urandom_range(199) == 0) cfg_step = W'($urandom);
         clr = ($urandom_range(59) == 0);
         c_srdy = ($urandom_range(3) != 0);
         r = int'($urandom_range(15));
         ch = (r == 15) ? 3 : r % 3;
         c_chan = CW'(ch);
         if (ch < CH && !m_first[ch] && $urandom_range(9) != 0)
            c_data = W'(m_last[ch] + int'(cfg_step));
         else
            c_data = W'($urandom);
         @(posedge clk); #1;
      end
      clr = 0; c_srdy = 0;
      idle(2);
      mon_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
